// File: rtl/wb_reg_file.sv
// wb_reg_file: register file fed by the Write Back stage's write port.
//   Commits WB writes, serves two registered read ports to Decode with
//   same-edge write-to-read bypass, zeroes itself after reset or soft clear,
//   and counts committed writes (saturating).
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_soft_clear         synchronous request to re-run the zeroing sequence
//   i_wr_en/dst/data     WB write port
//   i_rd_en              read request for both ports
//   i_rd_addr_a/b        read indices
//   o_rd_data_a/b        registered read data
//   o_rd_valid           one-cycle pulse when read data updated
//   o_ready              zeroing complete, accesses accepted
//   o_wr_count           committed writes since last init
module wb_reg_file #(
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 3,
  parameter bit          REG0_ZERO = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_soft_clear,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_dst,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  output logic [DATA_W-1:0] o_rd_data_a,
  output logic [DATA_W-1:0] o_rd_data_b,
  output logic              o_rd_valid,
  output logic              o_ready,
  output logic [CNT_W-1:0]  o_wr_count
);

  typedef enum logic {StInit, StReady} state_e;

  localparam logic [ADDR_W-1:0] LastPtr    = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   NumRegsExt = (ADDR_W + 1)'(NUM_REGS);

  state_e              r_state, w_state_d;
  logic [ADDR_W-1:0]   r_ptr, w_ptr_d;
  logic [DATA_W-1:0]   r_mem [NUM_REGS];
  logic [DATA_W-1:0]   r_rd_data_a, r_rd_data_b;
  logic                r_rd_valid;
  logic [CNT_W-1:0]    r_wr_count;

  logic                w_active;
  logic                w_wr_legal;
  logic                w_rd_fire;
  logic [DATA_W-1:0]   w_rd_val_a, w_rd_val_b;

  // A soft clear on a READY edge pre-empts any access on that edge.
  assign w_active   = (r_state == StReady) && !i_soft_clear;
  assign w_wr_legal = w_active && i_wr_en && ({1'b0, i_wr_dst} < NumRegsExt) &&
                      !(REG0_ZERO && (i_wr_dst == '0));
  assign w_rd_fire  = w_active && i_rd_en;

  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    unique case (r_state)
      StInit: begin
        if (i_soft_clear) begin
          w_ptr_d = '0;
        end else if (r_ptr == LastPtr) begin
          w_state_d = StReady;
          w_ptr_d   = '0;
        end else begin
          w_ptr_d = r_ptr + 1'b1;
        end
      end
      StReady: begin
        if (i_soft_clear) begin
          w_state_d = StInit;
          w_ptr_d   = '0;
        end
      end
      default: begin
        w_state_d = StInit;
        w_ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StInit;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
    end
  end

  // Array has no reset; the INIT sweep zeroes it.
  always_ff @(posedge i_clk) begin
    if (r_state == StInit) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_legal) begin
      r_mem[i_wr_dst] <= i_wr_data;
    end
  end

  // Out-of-range and hard-wired-zero addresses read 0, never bypassed.
  always_comb begin
    w_rd_val_a = '0;
    if (({1'b0, i_rd_addr_a} < NumRegsExt) && !(REG0_ZERO && (i_rd_addr_a == '0))) begin
      w_rd_val_a = (w_wr_legal && (i_wr_dst == i_rd_addr_a)) ? i_wr_data : r_mem[i_rd_addr_a];
    end
  end

  always_comb begin
    w_rd_val_b = '0;
    if (({1'b0, i_rd_addr_b} < NumRegsExt) && !(REG0_ZERO && (i_rd_addr_b == '0))) begin
      w_rd_val_b = (w_wr_legal && (i_wr_dst == i_rd_addr_b)) ? i_wr_data : r_mem[i_rd_addr_b];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data_a <= '0;
      r_rd_data_b <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_data_a <= w_rd_val_a;
        r_rd_data_b <= w_rd_val_b;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_count <= '0;
    end else if ((r_state == StInit) || i_soft_clear) begin
      r_wr_count <= '0;
    end else if (w_wr_legal && (r_wr_count != '1)) begin
      r_wr_count <= r_wr_count + 1'b1;
    end
  end

  assign o_rd_data_a = r_rd_data_a;
  assign o_rd_data_b = r_rd_data_b;
  assign o_rd_valid  = r_rd_valid;
  assign o_ready     = (r_state == StReady);
  assign o_wr_count  = r_wr_count;

endmodule

// File: tb/tb_wb_reg_file.sv
// Directed self-checking bench for wb_reg_file. Two instances share every
// input: one with the default 16-bit write counter, one with a 4-bit counter
// to exercise saturation.
module tb_wb_reg_file;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       soft_clear;
  logic       wr_en;
  logic [2:0] wr_dst;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [2:0] rd_addr_a, rd_addr_b;

  logic [7:0]  rd_data_a, rd_data_b, rd_data_a4, rd_data_b4;
  logic        rd_valid, ready, rd_valid4, ready4;
  logic [15:0] wr_count;
  logic [3:0]  wr_count4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_reg_file #(.CNT_W(16)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_soft_clear(soft_clear),
    .i_wr_en(wr_en), .i_wr_dst(wr_dst), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .i_rd_addr_a(rd_addr_a), .i_rd_addr_b(rd_addr_b),
    .o_rd_data_a(rd_data_a), .o_rd_data_b(rd_data_b), .o_rd_valid(rd_valid),
    .o_ready(ready), .o_wr_count(wr_count)
  );

  wb_reg_file #(.CNT_W(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_soft_clear(soft_clear),
    .i_wr_en(wr_en), .i_wr_dst(wr_dst), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .i_rd_addr_a(rd_addr_a), .i_rd_addr_b(rd_addr_b),
    .o_rd_data_a(rd_data_a4), .o_rd_data_b(rd_data_b4), .o_rd_valid(rd_valid4),
    .o_ready(ready4), .o_wr_count(wr_count4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    soft_clear = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; idle();
    wr_dst = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    step(); step();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data_a", 32'(rd_data_a), 32'd0);
    check("rst_data_b", 32'(rd_data_b), 32'd0);
    check("rst_count", 32'(wr_count), 32'd0);

    // T1: ready rises on the 8th edge after release.
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("t1_ready_e%0d", i), 32'(ready), (i == 8) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
      step();
      check($sformatf("t1_rd_a%0d", i), 32'(rd_data_a), 32'd0);
      check($sformatf("t1_rd_b%0d", i), 32'(rd_data_b), 32'd0);
      check("t1_valid", 32'(rd_valid), 32'd1);
    end
    idle(); step();
    check("t1_valid_drop", 32'(rd_valid), 32'd0);

    // T2: write then read.
    wr_en = 1'b1; wr_dst = 3'd3; wr_data = 8'h5A;
    step();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd0;
    step();
    check("t2_data_a", 32'(rd_data_a), 32'h5A);
    check("t2_data_b", 32'(rd_data_b), 32'h00);
    check("t2_valid", 32'(rd_valid), 32'd1);
    check("t2_count", 32'(wr_count), 32'd1);
    check("t2_count4", 32'(wr_count4), 32'd1);

    // T3: same-edge bypass on both ports.
    wr_en = 1'b1; wr_dst = 3'd5; wr_data = 8'hC3;
    rd_en = 1'b1; rd_addr_a = 3'd5; rd_addr_b = 3'd5;
    step();
    check("t3_byp_a", 32'(rd_data_a), 32'hC3);
    check("t3_byp_b", 32'(rd_data_b), 32'hC3);
    check("t3_valid", 32'(rd_valid), 32'd1);
    idle(); step();
    check("t3_valid_off", 32'(rd_valid), 32'd0);
    check("t3_hold_a", 32'(rd_data_a), 32'hC3);
    check("t3_hold_b", 32'(rd_data_b), 32'hC3);
    check("t3_count", 32'(wr_count), 32'd2);

    // T4: writes to r0 are dropped and uncounted.
    wr_en = 1'b1; wr_dst = 3'd0; wr_data = 8'hFF;
    step();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr_a = 3'd0; rd_addr_b = 3'd3;
    step();
    check("t4_r0", 32'(rd_data_a), 32'h00);
    check("t4_r3", 32'(rd_data_b), 32'h5A);
    check("t4_count", 32'(wr_count), 32'd2);

    // T5: soft clear beats a same-edge write and read.
    soft_clear = 1'b1; wr_en = 1'b1; wr_dst = 3'd2; wr_data = 8'h11;
    rd_en = 1'b1; rd_addr_a = 3'd5; rd_addr_b = 3'd5;
    step();
    idle();
    check("t5_ready", 32'(ready), 32'd0);
    check("t5_valid", 32'(rd_valid), 32'd0);
    check("t5_hold_a", 32'(rd_data_a), 32'h00);
    check("t5_hold_b", 32'(rd_data_b), 32'h5A);
    check("t5_count", 32'(wr_count), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("t5_ready_e%0d", i), 32'(ready), (i == 8) ? 32'd1 : 32'd0);
    end
    rd_en = 1'b1; rd_addr_a = 3'd2; rd_addr_b = 3'd3;
    step();
    idle();
    check("t5_r2", 32'(rd_data_a), 32'h00);
    check("t5_r3", 32'(rd_data_b), 32'h00);
    check("t5_count0", 32'(wr_count), 32'd0);

    // T6: 20 legal writes saturate the 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_dst = 3'(1 + (i % 7)); wr_data = 8'(8'h20 + i);
      step();
    end
    wr_en = 1'b0;
    check("t6_count4_sat", 32'(wr_count4), 32'hF);
    check("t6_count16", 32'(wr_count), 32'd20);
    rd_en = 1'b1; rd_addr_a = 3'd1; rd_addr_b = 3'd6;
    step();
    idle();
    check("t6_r1", 32'(rd_data_a), 32'h2E);
    check("t6_r6", 32'(rd_data_b), 32'h33);

    soft_clear = 1'b1;
    step();
    idle();
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_data_a", 32'(rd_data_a), 32'h00);
    check("t6_async_data_b", 32'(rd_data_b), 32'h00);
    check("t6_async_ready", 32'(ready), 32'd0);
    check("t6_async_count4", 32'(wr_count4), 32'd0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("t6_ready_e%0d", i), 32'(ready4), (i == 8) ? 32'd1 : 32'd0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
